iterative_shifter: RTL and testbench

//  Multi-cycle, parametrised shift unit for the pipelined RISC-V core: performs SLL/SRL/SRA
//  (optionally ROL) on an N-bit operand by a run-time amount, STEP bits per cycle.

---
 rtl/iterative_shifter_pkg.sv | 17 +
 rtl/iterative_shifter_if.sv | 17 +
 rtl/iterative_shifter_shift_step.sv | 31 +++
 rtl/iterative_shifter.sv | 83 ++++++++
 tb/tb_iterative_shifter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/iterative_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package iterative_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/iterative_shifter_if.sv
// Request/response bundle between the EX stage and the iterative shifter.
// Handshake: start is only taken while busy=0; done pulses one cycle with out valid,
// and out then holds until the next accepted start completes.
interface iterative_shifter_if #(
  parameter int N = 32
);
  logic                 start;
  logic [1:0]           op;
  logic [N-1:0]         a;
  logic [$clog2(N)-1:0] shamt;
  logic                 busy;
  logic                 done;
  logic [N-1:0]         out;

  modport master (output start, op, a, shamt, input busy, done, out);
  modport slave  (input start, op, a, shamt, output busy, done, out);
endinterface

// File: rtl/iterative_shifter_shift_step.sv
// One combinational shift step of 0..STEP bits with SLL/SRL/SRA fill rules.
// Rotate-left is present only when ITERATIVE_SHIFTER_ROTATE_EN is defined.
module iterative_shifter_shift_step
  import iterative_shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4,
  parameter int AW   = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  din,
  input  logic [AW-1:0] amt,
  input  shift_op_e     op,
  output logic [N-1:0]  dout
);
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
  logic [2*N-1:0] dbl;
  assign dbl = {din, din} << amt;
`endif

  always_comb begin
    dout = din << amt;
    case (op)
      OP_SRL: dout = din >> amt;
      OP_SRA: dout = $signed(din) >>> amt;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      OP_ROL: dout = dbl[2*N-1:N];
`endif
      default: dout = din << amt;
    endcase
  end
endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shifter: SLL/SRL/SRA (ROL with ITERATIVE_SHIFTER_ROTATE_EN), up to STEP bits
// per cycle, with start/busy/done handshake. FSM state is exported on dbg_state.
module iterative_shifter
  import iterative_shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4
) (
  input  logic                clk,
  input  logic                rst,
  iterative_shifter_if.slave  bus,
  output state_e              dbg_state
);
  localparam int RW = $clog2(N);
  localparam int AW = $clog2(STEP + 1);
  localparam logic [RW:0] STEP_EXT = (RW + 1)'(STEP);

  state_e          state, state_nx;
  logic [N-1:0]    acc, out_q, step_out;
  logic [RW-1:0]   remaining, rem_nx;
  logic [AW-1:0]   amt;
  shift_op_e       op_q;

  // amt = min(remaining, STEP); rem_nx therefore never wraps below zero
  always_comb begin
    amt = AW'(remaining);
    if ({1'b0, remaining} > STEP_EXT) amt = AW'(STEP);
    rem_nx = remaining - RW'(amt);
  end

  iterative_shifter_shift_step #(.N(N), .STEP(STEP), .AW(AW)) u_step (
    .din  (acc),
    .amt  (amt),
    .op   (op_q),
    .dout (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = (bus.shamt == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (rem_nx == '0) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      op_q      <= OP_SLL;
      out_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            acc       <= bus.a;
            remaining <= bus.shamt;
            op_q      <= shift_op_e'(bus.op);
          end
        end
        S_SHIFT: begin
          acc       <= step_out;
          remaining <= rem_nx;
        end
        S_DONE:  out_q <= acc;
        default: out_q <= out_q;
      endcase
    end
  end

  // During DONE the result is forwarded straight from acc so it is visible with the pulse
  assign bus.busy  = (state != S_IDLE);
  assign bus.done  = (state == S_DONE);
  assign bus.out   = (state == S_DONE) ? acc : out_q;
  assign dbg_state = state;
endmodule

// File: tb/tb_iterative_shifter.sv
// Directed bench for iterative_shifter (N=32, STEP=4); honours ITERATIVE_SHIFTER_ROTATE_EN.
module tb_iterative_shifter;
  import iterative_shifter_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_e dbg_state;
  int     tests = 0;
  int     fails = 0;

  iterative_shifter_if #(.N(32)) bus ();

  iterative_shifter #(.N(32), .STEP(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference behaviour: shift semantics from plain arithmetic
  function automatic logic [31:0] model_result(logic [1:0] o, logic [31:0] v, int s);
    case (o)
      2'b01:   return v >> s;
      2'b10:   return $signed(v) >>> s;
`ifdef ITERATIVE_SHIFTER_ROTATE_EN
      2'b11:   return (s == 0) ? v : ((v << s) | (v >> (32 - s)));
`endif
      default: return v << s;
    endcase
  endfunction

  // Timeline model: an op accepted at edge e0 is busy after edges e0..e0+ceil(s/4), done at the last
  int          cyc = 0;
  bit          m_active = 1'b0;
  int          m_last = 0;
  logic [31:0] m_out = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_active = 1'b0;
      m_out    = '0;
      exp_q.delete();
    end else begin
      if ((!m_active || cyc > m_last + 1) && bus.start) begin
        m_active = 1'b1;
        m_last   = cyc + (int'(bus.shamt) + 3) / 4;
        exp_q.push_back(model_result(bus.op, bus.a, int'(bus.shamt)));
      end
      if (m_active && cyc == m_last && exp_q.size() > 0) m_out = exp_q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      check("cyc busy", {31'b0, bus.busy}, {31'b0, m_active && cyc <= m_last});
      check("cyc done", {31'b0, bus.done}, {31'b0, m_active && cyc == m_last});
      check("cyc out", bus.out, m_out);
    end
  end

  task automatic run_op(string name, logic [1:0] o, logic [31:0] av, logic [4:0] s,
                        logic [31:0] exp_out, int exp_lat);
    int k;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.a = av; bus.shamt = s;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.shamt = 5'($urandom_range(0, 31));
    k = 1; seen = 1'b0;
    while (!seen && k < 40) begin
      if (bus.done) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s timeout: no done within 40 cycles, expected cycle %0d", name, exp_lat);
    end else begin
      check({name, " latency"}, 32'(k), 32'(exp_lat));
      check({name, " out"}, bus.out, exp_out);
      check({name, " model"}, m_out, exp_out);
    end
  endtask

  initial begin
    int pulses;
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.shamt = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    check("reset out", bus.out, 32'd0);
    rst = 1'b0;

    run_op("sll12",  2'b00, 32'h0000_0001, 5'd12, 32'h0000_1000, 4);
    run_op("sra31",  2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9);
    run_op("srl31",  2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 9);
    for (int o = 0; o < 4; o++)
      run_op("zero", 2'(o), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1);
    run_op("sll7",   2'b00, 32'h1234_5678, 5'd7,  32'h1A2B_3C00, 3);
    run_op("sra4",   2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 2);
    run_op("sra1",   2'b10, 32'hF000_0000, 5'd1,  32'hF800_0000, 2);
    run_op("srl5",   2'b01, 32'hDEAD_BEEF, 5'd5,  32'h06F5_6DF7, 3);

    // start held through SHIFT with different operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.a = 32'hF000_0000; bus.shamt = 5'd8;
    @(negedge clk);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 2) begin bus.a = 32'h1; bus.shamt = 5'd1; bus.start = 1'b1; end
      else bus.start = 1'b0;
      if (bus.done) begin
        pulses++;
        check("ignore latency", 32'(k), 32'd3);
        check("ignore out", bus.out, 32'h00F0_0000);
      end
      @(negedge clk);
    end
    check("ignore pulses", 32'(pulses), 32'd1);
    check("ignore hold", bus.out, 32'h00F0_0000);

    // reset in the middle of a long SLL
    bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'h3; bus.shamt = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset busy", {31'b0, bus.busy}, 32'd0);
    check("midreset done", {31'b0, bus.done}, 32'd0);
    check("midreset out", bus.out, 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done) pulses++;
      @(negedge clk);
    end
    check("midreset no done", 32'(pulses), 32'd0);
    run_op("post reset", 2'b00, 32'h0000_0003, 5'd20, 32'h0030_0000, 6);

`ifdef ITERATIVE_SHIFTER_ROTATE_EN
    run_op("op11", 2'b11, 32'h8000_0001, 5'd4, 32'h0000_0018, 2);
    run_op("rol31", 2'b11, 32'h0000_0003, 5'd31, 32'h8000_0001, 9);
`else
    run_op("op11", 2'b11, 32'h8000_0001, 5'd4, 32'h0000_0010, 2);
    run_op("op11 31", 2'b11, 32'h0000_0003, 5'd31, 32'h8000_0000, 9);
`endif

    repeat (3) @(negedge clk);
    check("final hold", bus.out, m_out);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
